// File: rtl/register_formatter_pkg.sv
// register_formatter shared types, ASCII constants and digit-split helpers.
// Imported by the formatter top and the ABI name ROM.
package register_formatter_pkg;

  localparam logic [7:0] PREFIX_CHAR = 8'h72;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam int ABI_NAME_MAX_LEN    = 4;

  typedef enum logic [2:0] {
    IDLE,
    PREFIX,
    TENS,
    ONES,
    DELIM,
    EMIT_NAME
  } fmt_state_t;

  function automatic logic [1:0] digit_tens(
    input logic [4:0] r
  );
    if (r >= 5'd30) return 2'd3;
    if (r >= 5'd20) return 2'd2;
    if (r >= 5'd10) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] digit_ones(
    input logic [4:0] r
  );
    logic [4:0] t;
    t = 5'd10 * {3'b000, digit_tens(r)};
    return 4'(r - t);
  endfunction

endpackage

// File: rtl/register_formatter_if.sv
// Request and character-stream handshake bundle.
// master: request source / char sink; slave: the formatter.
interface register_formatter_if;

  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_register;
  logic       req_sep;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_ascii;
  logic       out_last;

  modport master (
    output req_valid, req_register, req_sep, out_ready,
    input  req_ready, out_valid, out_ascii, out_last
  );

  modport slave (
    input  req_valid, req_register, req_sep, out_ready,
    output req_ready, out_valid, out_ascii, out_last
  );

endinterface

// File: rtl/register_formatter_reg_abi_name_rom.sv
// reg_abi_name_rom: register + char index -> ABI name char, plus name length.
// Combinational; only built when REGISTER_FORMATTER_ABI_EN is defined.
`ifdef REGISTER_FORMATTER_ABI_EN
module reg_abi_name_rom
  import register_formatter_pkg::*;
(
  input  logic [4:0] reg_num,
  input  logic [1:0] idx,
  output logic [7:0] char_out,
  output logic [2:0] name_len
);

  // Name packed MSB-first, zero padded to 4 chars.
  logic [31:0] name;

  always_comb begin
    name     = 32'h0;
    name_len = 3'd2;
    unique case (1'b1)
      reg_num == 5'd0: begin
        name     = "zero";
        name_len = 3'd4;
      end
      reg_num == 5'd1: name = {"ra", 16'h0};
      reg_num == 5'd2: name = {"sp", 16'h0};
      reg_num == 5'd3: name = {"gp", 16'h0};
      reg_num == 5'd4: name = {"tp", 16'h0};
      reg_num inside {[5'd5:5'd7]}:
        name = {"t", ASCII_ZERO + 8'(reg_num - 5'd5), 16'h0};
      reg_num inside {[5'd8:5'd9]}:
        name = {"s", ASCII_ZERO + 8'(reg_num - 5'd8), 16'h0};
      reg_num inside {[5'd10:5'd17]}:
        name = {"a", ASCII_ZERO + 8'(reg_num - 5'd10), 16'h0};
      reg_num inside {[5'd18:5'd25]}:
        name = {"s", ASCII_ZERO + 8'(reg_num - 5'd16), 16'h0};
      reg_num inside {[5'd26:5'd27]}: begin
        name     = {"s1", ASCII_ZERO + 8'(reg_num - 5'd26), 8'h0};
        name_len = 3'd3;
      end
      default:
        name = {"t", ASCII_ZERO + 8'(reg_num - 5'd25), 16'h0};
    endcase
  end

  always_comb begin
    char_out = 8'h0;
    unique case (idx)
      2'd0: char_out = name[31:24];
      2'd1: char_out = name[23:16];
      2'd2: char_out = name[15:8];
      default: char_out = name[7:0];
    endcase
  end

endmodule
`endif

// File: rtl/register_formatter.sv
// register_formatter: streams a register operand as ASCII, one char per handshake.
// Ports: clk_in, rst_in (async low), bus (slave), busy_flag. Macro: REGISTER_FORMATTER_ABI_EN.
module register_formatter
  import register_formatter_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  register_formatter_if.slave  bus,
  output logic                 busy_flag
);

  fmt_state_t state_q, state_d;
  logic [4:0] reg_q, reg_d;
  logic       sep_q, sep_d;
  logic [7:0] ascii_q, ascii_d;
  logic       last_q, last_d;
  logic       fire_out;
  logic [7:0] delim;

`ifdef REGISTER_FORMATTER_ABI_EN
  logic [1:0] idx_q, idx_d;
  logic [4:0] rom_reg;
  logic [1:0] rom_idx;
  logic [7:0] rom_char;
  logic [2:0] rom_len;

  // In IDLE the ROM looks at the incoming request so the first
  // name char can be registered on the accept edge.
  assign rom_reg = (state_q == IDLE) ? bus.req_register : reg_q;
  assign rom_idx = (state_q == IDLE) ? 2'd0 : idx_q + 2'd1;

  reg_abi_name_rom u_rom (
    .reg_num  (rom_reg),
    .idx      (rom_idx),
    .char_out (rom_char),
    .name_len (rom_len)
  );
`endif

  assign fire_out      = bus.out_valid && bus.out_ready;
  assign delim         = sep_q ? ASCII_SPACE : ASCII_COMMA;
  assign bus.out_valid = (state_q != IDLE);
  assign bus.req_ready = (state_q == IDLE);
  assign bus.out_ascii = ascii_q;
  assign bus.out_last  = last_q;
  assign busy_flag     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    sep_d   = sep_q;
    ascii_d = ascii_q;
    last_d  = last_q;
`ifdef REGISTER_FORMATTER_ABI_EN
    idx_d   = idx_q;
`endif
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        reg_d  = bus.req_register;
        sep_d  = bus.req_sep;
        last_d = 1'b0;
`ifdef REGISTER_FORMATTER_ABI_EN
        state_d = EMIT_NAME;
        ascii_d = rom_char;
        idx_d   = 2'd0;
`else
        state_d = PREFIX;
        ascii_d = PREFIX_CHAR;
`endif
      end
      PREFIX: if (fire_out) begin
        state_d = TENS;
        ascii_d = ASCII_ZERO + {6'b0, digit_tens(reg_q)};
      end
      TENS: if (fire_out) begin
        state_d = ONES;
        ascii_d = ASCII_ZERO + {4'b0, digit_ones(reg_q)};
      end
      ONES: if (fire_out) begin
        state_d = DELIM;
        ascii_d = delim;
        last_d  = 1'b1;
      end
`ifdef REGISTER_FORMATTER_ABI_EN
      EMIT_NAME: if (fire_out) begin
        if ({1'b0, idx_q} == rom_len - 3'd1) begin
          state_d = DELIM;
          ascii_d = delim;
          last_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 2'd1;
          ascii_d = rom_char;
        end
      end
`endif
      DELIM: if (fire_out) begin
        state_d = IDLE;
        ascii_d = 8'h00;
        last_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      reg_q   <= '0;
      sep_q   <= 1'b0;
      ascii_q <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      sep_q   <= sep_d;
      ascii_q <= ascii_d;
      last_q  <= last_d;
    end
  end

`ifdef REGISTER_FORMATTER_ABI_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) idx_q <= 2'd0;
    else         idx_q <= idx_d;
  end
`endif

endmodule

// File: tb/tb_register_formatter.sv
// Randomized self-checking bench for register_formatter.
// Expected strings come from a textual model of the register name.
module tb_register_formatter;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic busy_flag;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] exp_q[$];

  register_formatter_if ifc();

  register_formatter u_dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .bus       (ifc.slave),
    .busy_flag (busy_flag)
  );

  always #5 clk_in = ~clk_in;

`ifdef REGISTER_FORMATTER_ABI_EN
  string abi_names [32] = '{
    "zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
    "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
    "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
    "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"
  };
`endif

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input logic [4:0] r, input logic s);
    int v;
    v = int'(r);
    exp_q.delete();
`ifdef REGISTER_FORMATTER_ABI_EN
    for (int i = 0; i < abi_names[v].len(); i++)
      exp_q.push_back(abi_names[v][i]);
`else
    exp_q.push_back(8'h72);
    exp_q.push_back(8'(8'h30 + v / 10));
    exp_q.push_back(8'(8'h30 + v % 10));
`endif
    exp_q.push_back(s ? 8'h20 : 8'h2C);
  endtask

  // mode 0: out_ready held 1; 1: random backpressure;
  // 2: req_valid held with a different register while busy.
  task automatic do_seq(
    input logic [4:0] r,
    input logic       s,
    input int         mode
  );
    logic [7:0] got_c[$];
    logic       got_l[$];
    logic       held;
    logic [7:0] held_c;
    logic       held_l;
    int         cyc;
    build_exp(r, s);
    @(negedge clk_in);
    ifc.req_register = r;
    ifc.req_sep      = s;
    ifc.req_valid    = 1'b1;
    ifc.out_ready    = 1'b1;
    chk("req_ready_idle", ifc.req_ready, 1);
    @(negedge clk_in);
    if (mode == 2) begin
      ifc.req_register = ~r;
      ifc.req_sep      = ~s;
    end else begin
      ifc.req_valid = 1'b0;
    end
    chk("latency_valid", ifc.out_valid, 1);
    chk("first_char", ifc.out_ascii, exp_q[0]);
    cyc  = 0;
    held = 1'b0;
    held_c = 8'h0;
    held_l = 1'b0;
    while (got_c.size() < exp_q.size() && cyc < 200) begin
      if (!ifc.out_valid) begin
        chk("valid_dropped", ifc.out_valid, 1);
        break;
      end
      if (held) begin
        chk("stable_char", ifc.out_ascii, held_c);
        chk("stable_last", ifc.out_last, held_l);
      end
      chk("busy_flag", busy_flag, 1);
      if (mode == 2) chk("ignore_req", ifc.req_ready, 0);
      ifc.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ifc.out_ready) begin
        got_c.push_back(ifc.out_ascii);
        got_l.push_back(ifc.out_last);
        held = 1'b0;
      end else begin
        held   = 1'b1;
        held_c = ifc.out_ascii;
        held_l = ifc.out_last;
      end
      cyc++;
      @(negedge clk_in);
    end
    chk("char_count", got_c.size(), exp_q.size());
    if (mode == 0) chk("burst_cycles", cyc, exp_q.size());
    for (int i = 0; i < got_c.size(); i++) begin
      chk($sformatf("char%0d_r%0d", i, r), got_c[i], exp_q[i]);
      chk($sformatf("last%0d_r%0d", i, r), got_l[i],
          32'(i == exp_q.size() - 1));
    end
    chk("post_valid", ifc.out_valid, 0);
    chk("post_ready", ifc.req_ready, 1);
    chk("post_busy", busy_flag, 0);
    ifc.req_valid = 1'b0;
    ifc.out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.req_valid    = 1'b0;
    ifc.req_register = '0;
    ifc.req_sep      = 1'b0;
    ifc.out_ready    = 1'b0;
    rst_in           = 1'b0;
    #12;
    chk("rst_valid", ifc.out_valid, 0);
    chk("rst_ascii", ifc.out_ascii, 0);
    chk("rst_last", ifc.out_last, 0);
    chk("rst_busy", busy_flag, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("rst_ready", ifc.req_ready, 1);

    do_seq(5'd5, 1'b0, 0);
    do_seq(5'd31, 1'b1, 0);
    do_seq(5'd9, 1'b0, 0);
    do_seq(5'd10, 1'b1, 0);
    do_seq(5'd29, 1'b0, 0);
    do_seq(5'd30, 1'b0, 0);
`ifdef REGISTER_FORMATTER_ABI_EN
    do_seq(5'd0, 1'b0, 0);
    do_seq(5'd27, 1'b0, 0);
    do_seq(5'd2, 1'b0, 0);
`endif
    repeat (20)
      do_seq(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1);
    do_seq(5'd17, 1'b1, 2);

    // Abort mid-string with asynchronous reset.
    @(negedge clk_in);
    ifc.req_register = 5'd12;
    ifc.req_sep      = 1'b0;
    ifc.req_valid    = 1'b1;
    ifc.out_ready    = 1'b1;
    @(negedge clk_in);
    ifc.req_valid = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("mid_busy", busy_flag, 1);
    rst_in = 1'b0;
    #1;
    chk("abort_valid", ifc.out_valid, 0);
    chk("abort_ascii", ifc.out_ascii, 0);
    chk("abort_busy", busy_flag, 0);
    @(negedge clk_in);
    chk("abort_hold", ifc.out_valid, 0);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("abort_ready", ifc.req_ready, 1);
    chk("abort_quiet", ifc.out_valid, 0);
    do_seq(5'd0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
